// File: rtl/fifo_uart_tx_if.sv
// Read-side connection between the byte FIFO and the UART transmitter.
// The transmitter (master) issues read strobes; the FIFO (slave) supplies the empty flag and data.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a byte FIFO and sends 8-bit frames LSB-first
// with start, optional even parity and 1 or 2 stop bits; all outputs registered.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          parity, parity_next;
  logic          tx_next, rd_next, busy_next, done_next;
  logic          bit_end;

  assign bit_end = (cnt == LAST_CLK);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    shreg_next  = shreg;
    parity_next = parity;

    unique case (state)
      IDLE: if (enable && !fifo.fifo_empty) state_next = REQ;
      REQ:  state_next = LOAD;
      LOAD: begin
        shreg_next  = fifo.fifo_data;
        parity_next = ^fifo.fifo_data;
        cnt_next    = '0;
        state_next  = START;
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = DATA;
        end else cnt_next = cnt + CW'(1);
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shreg_next = {1'b0, shreg[7:1]};
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) begin
            idx_next   = '0;
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end else cnt_next = cnt + CW'(1);
      end
      PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = STOP;
        end else cnt_next = cnt + CW'(1);
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (idx == LAST_STOP) begin
            idx_next   = '0;
            state_next = IDLE;
          end else idx_next = idx + 3'd1;
        end else cnt_next = cnt + CW'(1);
      end
      default: state_next = IDLE;
    endcase

    // Outputs are derived from the upcoming state so the registered copies line up with it.
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    rd_next   = (state_next == REQ);
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (cnt_next == LAST_CLK) && (idx_next == LAST_STOP);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      parity       <= 1'b0;
      tx           <= 1'b1;
      fifo.fifo_rd <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frames_sent  <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      idx          <= idx_next;
      shreg        <= shreg_next;
      parity       <= parity_next;
      tx           <= tx_next;
      fifo.fifo_rd <= rd_next;
      busy         <= busy_next;
      frame_done   <= done_next;
      frames_sent  <= frames_sent + {15'd0, done_next};
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E2 at 4 clocks/bit) fed by FIFO models,
// with a frame monitor that decodes tx and compares against a scoreboard of expected bytes.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b, enable_a, enable_b;
  logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [15:0] sent_a, sent_b;

  fifo_uart_tx_if fa ();
  fifo_uart_tx_if fb ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .fifo(fa.master),
    .tx(tx_a), .busy(busy_a), .frame_done(done_a), .frames_sent(sent_a));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .fifo(fb.master),
    .tx(tx_b), .busy(busy_b), .frame_done(done_b), .frames_sent(sent_b));

  typedef struct { logic [7:0] data; logic par; } exp_t;
  typedef struct { logic [7:0] data; logic par; logic [15:0] sent; } vec_t;

  exp_t sb_a[$], sb_b[$];
  int   rd_cyc_a[$], rd_cyc_b[$], start_a[$], start_b[$];
  int   checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: data appears the cycle after a read strobe
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  int wr_a = 0, rp_a = 0, wr_b = 0, rp_b = 0;
  always @(posedge clk) if (fa.fifo_rd) begin fa.fifo_data <= mem_a[rp_a % 64]; rp_a <= rp_a + 1; end
  always @(posedge clk) if (fb.fifo_rd) begin fb.fifo_data <= mem_b[rp_b % 64]; rp_b <= rp_b + 1; end
  assign fa.fifo_empty = (wr_a == rp_a);
  assign fb.fifo_empty = (wr_b == rp_b);

  always @(negedge clk) begin
    if (fa.fifo_rd === 1'b1) rd_cyc_a.push_back(cyc);
    if (fb.fifo_rd === 1'b1) rd_cyc_b.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic tx_of(input int w);   return (w == 0) ? tx_a : tx_b;       endfunction
  function automatic logic busy_of(input int w); return (w == 0) ? busy_a : busy_b;   endfunction
  function automatic logic done_of(input int w); return (w == 0) ? done_a : done_b;   endfunction
  function automatic logic rst_of(input int w);  return (w == 0) ? reset_a : reset_b; endfunction

  task automatic fifo_write(input int w, input logic [7:0] d);
    if (w == 0) begin mem_a[wr_a % 64] = d; wr_a++; end
    else        begin mem_b[wr_b % 64] = d; wr_b++; end
  endtask

  task automatic push(input int w, input logic [7:0] d, input logic par);
    exp_t e;
    e.data = d;
    e.par  = par;
    fifo_write(w, d);
    if (w == 0) sb_a.push_back(e); else sb_b.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int w, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_of(w) && n < budget);
    check("frame_done_seen", {31'd0, done_of(w)}, 32'd1);
  endtask

  // Frame monitor: samples every cycle of a frame, checks bit widths, stop bits and
  // frame_done position, then compares the decoded byte/parity against the scoreboard.
  task automatic monitor(input int w);
    int         nbits, done_cnt, done_pos, bad, stop_lo;
    logic [47:0] s;
    logic [7:0]  got;
    bit          abort;
    exp_t        e;
    nbits   = (w == 0) ? 10 : 12;
    stop_lo = (w == 0) ? 9 : 10;
    forever begin
      @(negedge clk);
      if (!rst_of(w) && busy_of(w) && tx_of(w) == 1'b0) begin
        if (w == 0) start_a.push_back(cyc); else start_b.push_back(cyc);
        s = '1; done_cnt = 0; done_pos = -1; abort = 1'b0;
        for (int c = 0; c < nbits * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_of(w)) begin abort = 1'b1; break; end
          s[c] = tx_of(w);
          if (done_of(w)) begin done_cnt++; done_pos = c; end
        end
        if (!abort) begin
          bad = 0;
          for (int k = 0; k < nbits; k++)
            for (int j = 1; j < CPB; j++)
              if (s[k*CPB+j] !== s[k*CPB]) bad++;
          check("bit_width", bad, 0);
          bad = 0;
          for (int c = stop_lo * CPB; c < nbits * CPB; c++) if (s[c] !== 1'b1) bad++;
          check("stop_bits_low", bad, 0);
          check("frame_done_pos", done_pos, nbits * CPB - 1);
          check("frame_done_count", done_cnt, 1);
          for (int i = 0; i < 8; i++) got[i] = s[(1 + i) * CPB];
          if ((w == 0 && sb_a.size() == 0) || (w == 1 && sb_b.size() == 0)) begin
            check("unexpected_frame", {24'd0, got}, 32'hffff_ffff);
          end else begin
            e = (w == 0) ? sb_a.pop_front() : sb_b.pop_front();
            check("tx_byte", {24'd0, got}, {24'd0, e.data});
            if (w == 1) check("parity_bit", {31'd0, s[9*CPB]}, {31'd0, e.par});
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl [6];
    int   base, viol;

    tbl[0] = '{8'h07, 1'b1, 16'd1};
    tbl[1] = '{8'h00, 1'b0, 16'd2};
    tbl[2] = '{8'hFF, 1'b0, 16'd3};
    tbl[3] = '{8'h80, 1'b1, 16'd4};
    tbl[4] = '{8'h5A, 1'b0, 16'd5};
    tbl[5] = '{8'h01, 1'b1, 16'd6};

    reset_a = 1'b1; reset_b = 1'b1; enable_a = 1'b0; enable_b = 1'b0;
    cycles(3);
    check("reset_tx", {31'd0, tx_a}, 32'd1);
    check("reset_rd", {31'd0, fa.fifo_rd}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    check("reset_sent", {16'd0, sent_a}, 32'd0);
    check("reset_tx_b", {31'd0, tx_b}, 32'd1);
    check("reset_busy_b", {31'd0, busy_b}, 32'd0);
    reset_a = 1'b0; reset_b = 1'b0;

    // single byte 0xA5
    push(0, 8'hA5, 1'b0);
    enable_a = 1'b1;
    wait_done(0, 200);
    check("single_sent", {16'd0, sent_a}, 32'd1);
    check("single_rd_count", rd_cyc_a.size(), 1);
    cycles(10);
    check("single_tx_idle", {31'd0, tx_a}, 32'd1);
    check("single_busy_idle", {31'd0, busy_a}, 32'd0);
    check("single_rd_after", rd_cyc_a.size(), 1);

    // back-to-back 0x00, 0xFF
    enable_a = 1'b0; reset_a = 1'b1;
    cycles(2);
    reset_a = 1'b0;
    base = rd_cyc_a.size();
    push(0, 8'h00, 1'b0);
    push(0, 8'hFF, 1'b0);
    enable_a = 1'b1;
    wait_done(0, 200);
    wait_done(0, 200);
    cycles(20);
    check("b2b_rd_count", rd_cyc_a.size() - base, 2);
    check("b2b_rd_spacing", rd_cyc_a[rd_cyc_a.size()-1] - rd_cyc_a[rd_cyc_a.size()-2], 43);
    check("b2b_start_spacing", start_a[start_a.size()-1] - start_a[start_a.size()-2], 43);
    check("b2b_sent", {16'd0, sent_a}, 32'd2);
    check("b2b_empty", {31'd0, fa.fifo_empty}, 32'd1);

    // enable low with 0x3C queued
    enable_a = 1'b0;
    push(0, 8'h3C, 1'b0);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fa.fifo_rd !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) viol++;
    end
    check("enable_low_idle", viol, 0);
    enable_a = 1'b1;
    @(negedge clk); check("enable_rd_cycle1", {31'd0, fa.fifo_rd}, 32'd1);
    @(negedge clk); check("enable_tx_cycle2", {31'd0, tx_a}, 32'd1);
    @(negedge clk); check("enable_start_cycle3", {31'd0, tx_a}, 32'd0);
    wait_done(0, 200);
    check("enable_sent", {16'd0, sent_a}, 32'd3);

    // reset during data bit 3 of 0x55; 0x66 must follow intact
    enable_a = 1'b0;
    cycles(2);
    fifo_write(0, 8'h55);
    push(0, 8'h66, 1'b0);
    enable_a = 1'b1;
    cycles(19);
    check("mid_bit3_level", {31'd0, tx_a}, 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    check("mid_reset_tx", {31'd0, tx_a}, 32'd1);
    check("mid_reset_busy", {31'd0, busy_a}, 32'd0);
    check("mid_reset_sent", {16'd0, sent_a}, 32'd0);
    @(negedge clk);
    base = rd_cyc_a.size();
    reset_a = 1'b0;
    wait_done(0, 200);
    check("after_reset_sent", {16'd0, sent_a}, 32'd1);
    check("after_reset_rd", rd_cyc_a.size() - base, 1);

    // frames_sent wrap
    @(negedge clk);
    force dut_a.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut_a.frames_sent;
    check("wrap_preload", {16'd0, sent_a}, 32'h0000_FFFF);
    push(0, 8'h81, 1'b0);
    wait_done(0, 200);
    check("wrap_sent", {16'd0, sent_a}, 32'd0);
    check("wrap_done", {31'd0, done_a}, 32'd1);

    // parity / two-stop-bit table on the second instance
    enable_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(1, tbl[i].data, tbl[i].par);
      wait_done(1, 300);
      check("tbl_sent", {16'd0, sent_b}, {16'd0, tbl[i].sent});
      @(negedge clk);
      check("tbl_busy_after", {31'd0, busy_b}, 32'd0);
    end

    cycles(10);
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the 64-entry byte FIFO from its read side and sends each byte as an asynchronous UART frame on a single line. It watches the FIFO's empty flag, issues one-cycle read strobes, and captures the byte in the cycle after each strobe. It serialises the byte LSB-first with start, optional parity and stop bits. It is the consumer of the FIFO's rd/empty/data_out ports and the last stage before the pad.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0: 1 inserts an even-parity bit after data bit 7.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  permits new frames to start; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  FIFO read strobe, one cycle per byte.
- fifo_data  in  8  FIFO data_out; valid only in the cycle after fifo_rd.
- tx  out  1  serial line; idle high.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.
- frames_sent  out  16  count of completed frames; wraps.

## Operation
- All outputs are registered. After a reset edge: tx=1, fifo_rd=0, busy=0, frame_done=0, frames_sent=0, state=IDLE.
- FSM states: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE: if enable=1 and fifo_empty=0, go to REQ. Otherwise stay.
- REQ: lasts exactly 1 cycle, with fifo_rd=1 and no other cycle asserting it. Go to LOAD.
- LOAD: lasts 1 cycle. fifo_data is sampled into an 8-bit shift register. The parity bit is computed as the XOR of the 8 bits. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
- DATA: sends 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7. Go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx=parity for CLKS_PER_BIT cycles, so the total count of 1s in data+parity is even. Go to STOP.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. On the last cycle: frame_done=1 and frames_sent increments. Go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and reloads 0 on each bit boundary.
- frames_sent is unsigned 16-bit modulo: 0xFFFF+1 → 0x0000.
- enable deasserted mid-frame: the current frame completes normally, and no new REQ is issued.
- fifo_empty changing outside IDLE is ignored.
- reset mid-frame: on the reset edge tx returns to 1 and the FSM returns to IDLE. The partially sent byte is discarded and not re-read. frames_sent returns to 0.
- fifo_empty=1 in IDLE: no strobe is issued and tx stays 1 indefinitely.

## Timing
- Cycle n: IDLE samples enable=1 and fifo_empty=0.
- Cycle n+1: fifo_rd=1.
- Cycle n+2: LOAD; the byte is captured at the end of this cycle.
- Cycle n+3: the first cycle with tx=0.
- Frame length from first start cycle to last stop cycle: (1+8+PARITY_EN+STOP_BITS)×CLKS_PER_BIT cycles.
- Back-to-back frames: the last stop cycle is followed by 3 cycles of tx=1 (IDLE, REQ, LOAD), then the next start bit.
- busy rises in cycle n+1 and falls in the cycle after frame_done.
- frame_done and the frames_sent increment are visible in the same cycle.

## Test plan
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1: write 0xA5 to the FIFO with enable=1. Required:
  - exactly one fifo_rd pulse;
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total;
  - then frame_done pulses once, frames_sent=1, tx stays 1.
- Back-to-back: preload 0x00 and 0xFF. Required:
  - two fifo_rd pulses 43 cycles apart;
  - 3 idle-high cycles between frames;
  - frames_sent=2;
  - fifo_empty=1 afterwards with no further fifo_rd.
- Parity, PARITY_EN=1, STOP_BITS=2: send 0x07. Required:
  - data bits 1,1,1,0,0,0,0,0;
  - parity bit = 1;
  - two stop bits, 8 cycles high;
  - frame length 48 cycles.
- enable low with 0x3C queued: no fifo_rd, tx=1, busy=0 for 100 cycles. Raising enable then starts the frame in the 3rd cycle after the rise.
- Reset during DATA bit 3 of 0x55: tx=1 and busy=0 on the reset edge, frames_sent=0. After reset release, the next queued byte (0x66) is read and sent intact.
- Counter wrap: force frames_sent to 0xFFFF, complete one frame. Required: frames_sent=0x0000 and frame_done=1 in the same cycle.
